// File: rtl/ct_hpcp_cnt_ctrl.sv
// Hardware performance counter control: event-select FSM, staged increment and 64-bit counter with sticky overflow.
// Optional overflow interrupt register is built only when HPCP_OVF_INT_EN is defined.
module ct_hpcp_cnt_ctrl (
    input  logic        cpuclk,
    input  logic        cpurst,
    input  logic        cnt_en,
    input  logic [3:0]  cnt_adder,
    input  logic        csr_wr_vld,
    input  logic [1:0]  csr_wr_sel,
    input  logic [63:0] csr_wr_data,
    output logic        csr_wr_ack,
    output logic [5:0]  evt_sel,
    output logic [63:0] cnt_value,
    output logic        cnt_ovf,
    output logic        cnt_ovf_int
);

    typedef enum logic [1:0] {
        ST_OFF    = 2'd0,
        ST_SETTLE = 2'd1,
        ST_RUN    = 2'd2
    } state_e;

    localparam logic [5:0] EVT_MAX = 6'd42;

    state_e      state_q, state_d;
    logic [5:0]  evt_sel_q, evt_sel_d;
    logic [3:0]  adder_q, adder_d;
    logic [63:0] cnt_q, cnt_d;
    logic        ovf_q, ovf_d;
    logic        ack_q, ack_d;
    logic [64:0] cnt_sum;

    logic wr_cnt, wr_evt, wr_clr, evt_valid;

    assign wr_cnt    = csr_wr_vld && (csr_wr_sel == 2'd0);
    assign wr_evt    = csr_wr_vld && (csr_wr_sel == 2'd1);
    assign wr_clr    = csr_wr_vld && (csr_wr_sel == 2'd2);
    assign evt_valid = (evt_sel_q != 6'd0) && (evt_sel_q <= EVT_MAX);

    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        state_d = state_q;
        if (wr_evt) begin
            state_d = ST_SETTLE;
        end else begin
            case (state_q)
                ST_OFF:    state_d = ST_OFF;
                ST_RUN:    state_d = ST_RUN;
                ST_SETTLE: state_d = evt_valid ? ST_RUN : ST_OFF;
                default:   state_d = ST_OFF;
            endcase
        end
    end

    // The selector output is only trusted in RUN; elsewhere a zero is staged so garbage never reaches the counter.
    always_comb begin
        adder_d   = '0;
        evt_sel_d = evt_sel_q;
        ack_d     = csr_wr_vld;
        if ((state_q == ST_RUN) && cnt_en && !wr_cnt) begin
            adder_d = cnt_adder;
        end
        if (wr_evt) begin
            evt_sel_d = csr_wr_data[5:0];
        end
    end

    assign cnt_sum = {1'b0, cnt_q} + {61'd0, adder_q};

    // A counter load beats both the increment and a carry; a carry beats an explicit overflow clear.
    always_comb begin
        cnt_d = cnt_sum[63:0];
        ovf_d = ovf_q;
        if (wr_cnt) begin
            cnt_d = csr_wr_data;
            ovf_d = 1'b0;
        end else if (cnt_sum[64]) begin
            ovf_d = 1'b1;
        end else if (wr_clr) begin
            ovf_d = 1'b0;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge cpuclk or posedge cpurst) begin
        if (cpurst) begin
            state_q   <= ST_OFF;
            evt_sel_q <= '0;
            adder_q   <= '0;
            cnt_q     <= '0;
            ovf_q     <= 1'b0;
            ack_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            evt_sel_q <= evt_sel_d;
            adder_q   <= adder_d;
            cnt_q     <= cnt_d;
            ovf_q     <= ovf_d;
            ack_q     <= ack_d;
        end
    end

`ifdef HPCP_OVF_INT_EN
    logic ovf_int_q, ovf_int_d;

    assign ovf_int_d = ovf_q;

    always_ff @(posedge cpuclk or posedge cpurst) begin
        if (cpurst) begin
            ovf_int_q <= 1'b0;
        end else begin
            ovf_int_q <= ovf_int_d;
        end
    end

    assign cnt_ovf_int = ovf_int_q;
`else
    assign cnt_ovf_int = 1'b0;
`endif

    assign csr_wr_ack = ack_q;
    assign evt_sel    = evt_sel_q;
    assign cnt_value  = cnt_q;
    assign cnt_ovf    = ovf_q;

endmodule

// File: doc/ct_hpcp_cnt_ctrl.md
CT_HPCP_CNT_CTRL -- requirements
Module: ct_hpcp_cnt_ctrl

Interface
REQ-001 SHALL have cpuclk, input, 1: sole clock; all flops rising-edge.
REQ-002 SHALL have cpurst, input, 1: asynchronous active-high reset.
REQ-003 SHALL have cnt_en, input, 1: counting permitted this cycle (mode filter and inhibit already applied upstream).
REQ-004 SHALL have cnt_adder, input, 4: per-cycle increment from the event adder selector, driven for the current evt_sel.
REQ-005 SHALL have csr_wr_vld, input, 1: CSR write strobe.
REQ-006 SHALL have csr_wr_sel, input, 2: write target. 0 = counter, 1 = event select, 2 = overflow clear, 3 = reserved.
REQ-007 SHALL have csr_wr_data, input, 64: write data; event select uses bits [5:0].
REQ-008 SHALL have csr_wr_ack, output, 1: one-cycle write acknowledge.
REQ-009 SHALL have evt_sel, output, 6: registered event id; drives the selector's event-value bits [5:0].
REQ-010 SHALL have cnt_value, output, 64: counter value.
REQ-011 SHALL have cnt_ovf, output, 1: sticky overflow flag.
REQ-012 SHALL have cnt_ovf_int, output, 1: overflow interrupt request.

Function
REQ-013 SHALL run a 3-state FSM.
- OFF: evt_sel is 0 or greater than 42.
- SETTLE: the single cycle after any event-select write.
- RUN: evt_sel is in 1..42 and the FSM is not in SETTLE.
REQ-014 Transitions SHALL be:
- any state -> SETTLE on an accepted sel=1 write;
- SETTLE -> RUN if the new evt_sel is in 1..42, else -> OFF;
- OFF <-> RUN only via SETTLE.
REQ-015 SHALL register adder_q <= cnt_adder when the state is RUN and cnt_en=1; otherwise adder_q <= 0. In OFF and SETTLE the selector's undefined output SHALL never reach the counter.
REQ-016 SHALL update the counter each cycle as cnt_value <= cnt_value + adder_q (zero-extended, modulo 2^64). Latency from cnt_adder to cnt_value is 2 cycles.
REQ-017 A carry out of bit 63 SHALL set cnt_ovf in the same cycle as the wrap. Example: FFFF_FFFF_FFFF_FFFE + 3 -> 1 with cnt_ovf=1.
REQ-018 A sel=0 write SHALL, on the next edge:
- load cnt_value with csr_wr_data;
- clear adder_q;
- clear cnt_ovf.
The write SHALL win over an increment in the same cycle.
REQ-019 A sel=2 write SHALL clear cnt_ovf. If an overflow carry occurs in the same cycle, set SHALL win and cnt_ovf stays 1.
REQ-020 A sel=1 write SHALL load evt_sel with csr_wr_data[5:0] and SHALL NOT alter cnt_value or cnt_ovf.
REQ-021 A sel=3 write SHALL be acknowledged with no state effect.
REQ-022 csr_wr_ack SHALL be registered csr_wr_vld: one pulse per write, 1-cycle latency. Back-to-back writes SHALL be accepted every cycle.

Reset
REQ-023 While cpurst=1 the block SHALL asynchronously force:
- FSM = OFF;
- evt_sel = 0, adder_q = 0, cnt_value = 0;
- cnt_ovf = 0, cnt_ovf_int = 0, csr_wr_ack = 0.
REQ-024 Reset asserted mid-count SHALL discard adder_q. The first increment after reset release SHALL require a sel=1 write followed by SETTLE.

Configuration
REQ-025 Macro HPCP_OVF_INT_EN defined: cnt_ovf_int SHALL be a registered copy of cnt_ovf, asserting 1 cycle after cnt_ovf rises and deasserting 1 cycle after it clears.
REQ-026 Macro HPCP_OVF_INT_EN undefined: cnt_ovf_int SHALL be tied 0 and the interrupt flop SHALL NOT exist. cnt_ovf behaviour SHALL be unchanged.

Verification
REQ-027 Scenario: reset; write sel=1 data=5; hold cnt_en=1 and cnt_adder=2 for 10 cycles -> ack 1 cycle after the write; cnt_value = 0 through SETTLE, then +2 per cycle, reaching 18 or more on schedule per REQ-016.
REQ-028 Scenario: evt_sel=0 and evt_sel=50, cnt_en=1, cnt_adder=X -> cnt_value stays constant and never goes X.
REQ-029 Scenario: write counter FFFF_FFFF_FFFF_FFFE, run evt 3 with adder=3 -> cnt_value=1 and cnt_ovf=1; with HPCP_OVF_INT_EN, cnt_ovf_int=1 one cycle later.
REQ-030 Scenario: sel=0 write of 100 in the same cycle adder_q=4 -> next cnt_value=100, not 104.
REQ-031 Scenario: sel=2 clear in the same cycle as a wrap -> cnt_ovf remains 1.
REQ-032 Scenario: assert cpurst mid-RUN -> all outputs 0 immediately (asynchronously); after release, cnt_adder=7 with cnt_en=1 leaves cnt_value=0.
